// File: rtl/credit_returner.sv
// credit_returner: receiver side of a credit link. Tracks local buffer
// occupancy, accumulates freed slots and returns them as credits to the
// sender counter. It also drives the counter's reinit port at startup and
// on resynchronisation.
module credit_returner #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 8,
    parameter int MAX_RET = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid_i,
    input  logic             free_valid_i,
    input  logic [1:0]       free_i,
    input  logic             sync_req_i,
    output logic             reinit_o,
    output logic [WIDTH-1:0] initial_value_o,
    output logic             incr_valid_o,
    output logic [1:0]       incr_o,
    output logic [WIDTH-1:0] occupancy_o,
    output logic [WIDTH-1:0] pending_o,
    output logic             err_o
);

    // Wide arithmetic width so sums and differences never wrap silently.
    localparam int WW = WIDTH + 2;
    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_RET);
    localparam logic [WW-1:0]    PEND_MAX = WW'({WIDTH{1'b1}});

    typedef enum logic [1:0] {IDLE, INIT, RUN, SYNC} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] occ_q, occ_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             err_q, err_d;

    logic [1:0]    ret;
    logic [1:0]    f;
    logic          overflow;
    logic          underflow;
    logic [WW-1:0] occ_avail;
    logic [WW-1:0] pend_sum;

    // Credits returned this cycle: only in RUN, at most MAX_RET per beat.
    always_comb begin
        ret = 2'd0;
        if (state_q == RUN) begin
            if (pend_q >= MAX_W) begin
                ret = 2'(MAX_RET);
            end else begin
                ret = 2'(pend_q);
            end
        end
    end

    // Next-state, occupancy, pending and error computation.
    always_comb begin
        f         = free_valid_i ? free_i : 2'd0;
        // A push into a full buffer is dropped so occupancy stays at DEPTH.
        overflow  = push_valid_i && (occ_q == DEPTH_W);
        occ_avail = WW'(occ_q) + WW'(push_valid_i && !overflow);
        underflow = WW'(f) > occ_avail;
        occ_d     = underflow ? '0 : WIDTH'(occ_avail - WW'(f));
        // ret never exceeds pend_q, so this cannot go negative.
        pend_sum  = WW'(pend_q) + WW'(f) - WW'(ret);

        state_d = state_q;
        err_d   = err_q | overflow | underflow;
        if (pend_sum > PEND_MAX) begin
            pend_d = WIDTH'(PEND_MAX);
        end else begin
            pend_d = WIDTH'(pend_sum);
        end

        case (state_q)
            IDLE: begin
                state_d = INIT;
                pend_d  = '0;
            end
            INIT: begin
                // Sender is being re-granted DEPTH; frees here are dropped.
                state_d = RUN;
                pend_d  = pend_q;
            end
            RUN: begin
                err_d = err_d | (pend_sum > PEND_MAX);
                if (sync_req_i) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (occ_d == '0) begin
                    state_d = INIT;
                    pend_d  = '0;
                end else begin
                    err_d = err_d | (pend_sum > PEND_MAX);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            occ_q   <= '0;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    assign reinit_o        = (state_q == INIT);
    assign initial_value_o = DEPTH_W;
    assign incr_valid_o    = (ret != 2'd0);
    assign incr_o          = ret;
    assign occupancy_o     = occ_q;
    assign pending_o       = pend_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_credit_returner.sv
// Directed bench for credit_returner (WIDTH=4, DEPTH=8, MAX_RET=3).
// Each step queues its expected post-edge outputs, then pops and checks them.
module tb_credit_returner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push_valid = 1'b0;
    logic       free_valid = 1'b0;
    logic [1:0] free = 2'd0;
    logic       sync_req = 1'b0;
    logic       reinit;
    logic [3:0] initial_value;
    logic       incr_valid;
    logic [1:0] incr;
    logic [3:0] occupancy;
    logic [3:0] pending;
    logic       err;

    int total = 0;
    int bad = 0;
    int nstep = 0;
    int ret_total = 0;

    typedef struct {
        logic reinit;
        int   incr;
        int   occ;
        int   pend;
        logic err;
    } exp_t;

    exp_t exp_q[$];

    credit_returner #(.WIDTH(4), .DEPTH(8), .MAX_RET(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .push_valid_i    (push_valid),
        .free_valid_i    (free_valid),
        .free_i          (free),
        .sync_req_i      (sync_req),
        .reinit_o        (reinit),
        .initial_value_o (initial_value),
        .incr_valid_o    (incr_valid),
        .incr_o          (incr),
        .occupancy_o     (occupancy),
        .pending_o       (pending),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_reinit"}, int'(reinit), 0);
        chk({tag, "_incr_valid"}, int'(incr_valid), 0);
        chk({tag, "_incr"}, int'(incr), 0);
        chk({tag, "_occ"}, int'(occupancy), 0);
        chk({tag, "_pend"}, int'(pending), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_init_val"}, int'(initial_value), 8);
        $display("reset check %s: reinit=%0d incr=%0d occ=%0d pend=%0d err=%0d",
                 tag, reinit, incr, occupancy, pending, err);
    endtask

    // Drive one cycle of inputs, queue expected outputs, check after the edge.
    task automatic step(input logic p, input logic fv, input logic [1:0] fr,
                        input logic s, input logic e_reinit, input int e_incr,
                        input int e_occ, input int e_pend, input logic e_err);
        exp_t e;
        push_valid = p;
        free_valid = fv;
        free       = fr;
        sync_req   = s;
        exp_q.push_back('{e_reinit, e_incr, e_occ, e_pend, e_err});
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        free_valid = 1'b0;
        free       = 2'd0;
        sync_req   = 1'b0;
        nstep++;
        e = exp_q.pop_front();
        ret_total += int'(incr);
        $display("step %0d: push=%0d free=%0d/%0d sync=%0d -> reinit=%0d incr_valid=%0d incr=%0d occ=%0d pend=%0d err=%0d",
                 nstep, p, fv, fr, s, reinit, incr_valid, incr, occupancy, pending, err);
        chk($sformatf("s%0d_reinit", nstep), int'(reinit), int'(e.reinit));
        chk($sformatf("s%0d_incr", nstep), int'(incr), e.incr);
        chk($sformatf("s%0d_incr_valid", nstep), int'(incr_valid), int'(e.incr != 0));
        chk($sformatf("s%0d_occ", nstep), int'(occupancy), e.occ);
        chk($sformatf("s%0d_pend", nstep), int'(pending), e.pend);
        chk($sformatf("s%0d_err", nstep), int'(err), int'(e.err));
    endtask

    initial begin
        // Held in reset across a couple of edges.
        repeat (2) @(posedge clk);
        #1;
        chk_reset("por");
        rst = 1'b0;

        // Reset release: one-cycle reinit, then RUN.
        step(0, 0, 2'd0, 0, 1, 0, 0, 0, 0);
        chk("init_value", int'(initial_value), 8);
        step(0, 0, 2'd0, 0, 0, 0, 0, 0, 0);

        // Four pushes then free 2: one-cycle free-to-return latency.
        for (int i = 1; i <= 4; i++) step(1, 0, 2'd0, 0, 0, 0, i, 0, 0);
        step(0, 1, 2'd2, 0, 0, 2, 2, 2, 0);
        step(0, 0, 2'd0, 0, 0, 0, 2, 0, 0);

        // Fill to 8, then free 3,3,1: 7 credits back, beats <= 3.
        for (int i = 3; i <= 8; i++) step(1, 0, 2'd0, 0, 0, 0, i, 0, 0);
        ret_total = 0;
        step(0, 1, 2'd3, 0, 0, 3, 5, 3, 0);
        step(0, 1, 2'd3, 0, 0, 3, 2, 3, 0);
        step(0, 1, 2'd1, 0, 0, 1, 1, 1, 0);
        step(0, 0, 2'd0, 0, 0, 0, 1, 0, 0);
        chk("backlog_total", ret_total, 7);

        // Resync at occupancy 3: frees accumulate silently until empty.
        step(1, 0, 2'd0, 0, 0, 0, 2, 0, 0);
        step(1, 0, 2'd0, 0, 0, 0, 3, 0, 0);
        step(0, 0, 2'd0, 1, 0, 0, 3, 0, 0);
        step(0, 1, 2'd1, 0, 0, 0, 2, 1, 0);
        step(0, 1, 2'd2, 0, 1, 0, 0, 0, 0);
        // sync_req during INIT is ignored; RUN resumes returning credits.
        step(0, 0, 2'd0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 2'd0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 2'd1, 0, 0, 1, 0, 1, 0);
        step(0, 0, 2'd0, 0, 0, 0, 0, 0, 0);

        // Underflow: free 2 at occupancy 1 saturates to 0 and sets err.
        step(1, 0, 2'd0, 0, 0, 0, 1, 0, 0);
        step(0, 1, 2'd2, 0, 0, 2, 0, 2, 1);
        step(0, 0, 2'd0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 2'd0, 0, 0, 0, 0, 0, 1);

        // Reset clears the sticky error.
        rst = 1'b1;
        #1;
        chk_reset("rst1");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 2'd0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 2'd0, 0, 0, 0, 0, 0, 0);

        // Fill to 8 and start a 3-beat return backlog.
        for (int i = 1; i <= 8; i++) step(1, 0, 2'd0, 0, 0, 0, i, 0, 0);
        step(0, 1, 2'd2, 0, 0, 2, 6, 2, 0);
        step(0, 1, 2'd3, 0, 0, 3, 3, 3, 0);
        step(0, 1, 2'd3, 0, 0, 3, 0, 3, 0);

        // Asynchronous reset mid-backlog: outputs drop before any edge.
        rst = 1'b1;
        #1;
        chk_reset("rst2");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 2'd0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 2'd0, 0, 0, 0, 0, 0, 0);

        // Overflow: push at occupancy 8 holds 8 and sets err, which sticks.
        for (int i = 1; i <= 8; i++) step(1, 0, 2'd0, 0, 0, 0, i, 0, 0);
        step(1, 0, 2'd0, 0, 0, 0, 8, 0, 1);
        step(0, 0, 2'd0, 0, 0, 0, 8, 0, 1);
        step(0, 1, 2'd1, 0, 0, 1, 7, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/credit_returner.md
# credit_returner

Receiver-side end of the credit flow-control link whose sender holds the `counter` credit tracker. The block tracks local buffer occupancy and accumulates slots freed by the local consumer. It returns those credits to the sender over the counter's increment port (`incr_valid`/`incr`). It also drives the counter's `reinit`/`initial_value` port at startup and on a resynchronisation request.

## Interface
Parameters:
- WIDTH, 4: width of the credit value, occupancy and pending registers; must match the sender counter width.
- DEPTH, 8: local buffer slots, which is also the initial credit grant; 1 ≤ DEPTH ≤ 2^WIDTH−1.
- MAX_RET, 3: maximum credits returned per cycle; 1..3 (bounded by the 2-bit `incr`).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- push_valid  input  1  one entry arrived from the sender this cycle, consuming one slot.
- free_valid  input  1  local consumer released slots this cycle.
- free  input  2  number of slots released, 0..3; qualified by free_valid.
- sync_req  input  1  single-cycle pulse requesting credit resynchronisation.
- reinit  output  1  to the sender counter: load initial_value.
- initial_value  output  WIDTH  constant DEPTH.
- incr_valid  output  1  credit return valid.
- incr  output  2  credits returned this cycle, 1..MAX_RET when valid, 0 otherwise.
- occupancy  output  WIDTH  slots currently held locally.
- pending  output  WIDTH  freed credits not yet returned.
- err  output  1  sticky protocol-error flag.

## Operation
- State machine states: IDLE, INIT, RUN, SYNC.
  - IDLE → INIT unconditionally. IDLE is the reset state.
  - INIT → RUN unconditionally.
  - RUN → SYNC on sync_req.
  - SYNC → INIT when occupancy == 0 in that cycle, after applying that cycle's push and free.
- reinit = (state == INIT). It is asserted for exactly one cycle per initialisation.
- Return amount: ret = (state == RUN) ? min(pending, MAX_RET) : 0. Output incr_valid = (ret != 0) and incr = ret. Both are combinational from registers only (Moore).
- Occupancy update: occupancy_next = occupancy + push_valid − f, where f = free_valid ? free : 0.
- Pending update:
  - On entry to INIT (from IDLE or SYNC), pending_next = 0.
  - In INIT, f is not added to pending.
  - Otherwise, pending_next = pending + f − ret.
- Frees in SYNC still accumulate in pending. They are discarded when INIT is entered, because the sender is re-granted the full DEPTH.
- No credits are returned in IDLE, INIT or SYNC.
- Error conditions: err is set, and stays set until rst, when any of these occur:
  - f > occupancy + push_valid (occupancy underflow). The update saturates occupancy at 0.
  - push_valid with occupancy == DEPTH (overflow). Occupancy holds at DEPTH.
  - pending + f − ret > 2^WIDTH−1. Pending saturates.
- A sync_req received in SYNC, INIT or IDLE is ignored.
- Invariant in RUN with no error: sender credits + occupancy + pending + ret in flight == DEPTH.

## Timing
- Reset values: state = IDLE, reinit = 0, incr_valid = 0, incr = 0, occupancy = 0, pending = 0, err = 0. initial_value = DEPTH at all times.
- Reset sequence:
  - First edge after rst deasserts: state moves IDLE → INIT, and reinit is high for that cycle.
  - Next edge: state enters RUN.
- Free-to-return latency is one cycle: a free in cycle t appears in pending at t+1, and incr is driven in cycle t+1 while in RUN.
- A backlog drains at MAX_RET per cycle. The final beat carries the remainder, e.g. pending 7 with MAX_RET 3 gives 3, 3, 1.
- Simultaneous push and free in the same cycle are both applied; net change to occupancy = push − f.
- Reset asserted mid-operation clears state immediately, including mid-SYNC. reinit, incr_valid and incr drop to 0 asynchronously.
- Resync latency: SYNC persists while occupancy > 0. reinit rises in the cycle after the cycle where occupancy reaches 0.

## Test plan
- Reset release with DEPTH = 8: reinit = 1 for exactly one cycle with initial_value = 8, then RUN. incr_valid = 0 throughout; occupancy = 0 and pending = 0.
- 4 single-cycle pushes, then free_valid with free = 2 in cycle t: occupancy goes 4 → 2. In cycle t+1, incr_valid = 1 and incr = 2; in cycle t+2, pending = 0 and incr_valid = 0.
- Backlog with MAX_RET = 3: fill occupancy to 8, then free 3, 3 and 1 on three consecutive cycles. Exactly 7 credits are returned in total; while the backlog drains, each beat is at most 3 and pending never exceeds 6.
- sync_req with occupancy = 3: no incr while in SYNC. Free 3 arrives → reinit pulse with initial_value = 8 the next cycle, pending = 0 afterwards, then RUN.
- Errors:
  - free = 2 with occupancy = 1 and no push: err = 1 and occupancy = 0.
  - Push at occupancy = 8: err = 1 and occupancy stays 8.
  - err persists until rst.
- Assert rst during a 3-cycle return backlog: incr_valid drops immediately; all outputs return to their reset values, followed by a fresh one-cycle reinit after release.
